// File: rtl/axil_reg_responder.sv
// ---------------------------------------------------------------------------
// axil_reg_responder
//
// AXI4-Lite subordinate register bank. Holds NUM_REGS 32-bit software
// registers that a bus master writes and reads, and exposes them flattened
// on REG_OUT for the attached datapath.
//
// Write side: the AW and W channels are captured independently into holding
// buffers, so they may arrive in either order or together. The register is
// committed on the edge where both are available, and one B beat follows.
// Read side: a two-state FSM (R_IDLE / R_RESP) answers each AR with one R beat.
// Out-of-range indices (idx >= NUM_REGS) answer SLVERR and touch nothing.
//
// Parameters
//   DATA_WIDTH : bus data width (only 32 is supported)
//   ADDR_WIDTH : bus address width; must be at least 3
//   NUM_REGS   : implemented registers, 1 .. 2**(ADDR_WIDTH-2)
//
// Ports
//   ACLK, ARESETN       : clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*: write address / data channels (AWPROT ignored)
//   S_AXI_B*            : write response channel
//   S_AXI_AR* / S_AXI_R*: read address / data channels (ARPROT ignored)
//   REG_OUT             : register k on bits [32k+31:32k]
//   REG_WR_PULSE        : one-cycle pulse on bit k when register k is written
// ---------------------------------------------------------------------------
module axil_reg_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  // write response channel
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  // read data channel
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  // datapath side
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]            REG_WR_PULSE
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // Goes high on the first edge after reset release; keeps every READY low
  // while reset is asserted and for the edge it is released on.
  logic                  rst_done;

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  bvalid;
  logic [1:0]            bresp;

  r_state_t              r_state;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse;

  // -------------------------------------------------------------------------
  // Handshakes and write-commit selection
  // -------------------------------------------------------------------------
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_value;

  assign S_AXI_AWREADY = rst_done && !aw_held && !bvalid;
  assign S_AXI_WREADY  = rst_done && !w_held && !bvalid;
  assign S_AXI_ARREADY = rst_done && (r_state == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A channel is "available" if it is already buffered or handshaking now;
  // the commit fires as soon as both are available, so a same-cycle AW+W
  // never passes through the buffers.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;

  assign wr_in_range = 32'(wr_idx) < NUM_REGS;

  assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_in_range = 32'(rd_idx) < NUM_REGS;

  // Read mux built as a compare loop so an index beyond NUM_REGS never
  // addresses a non-existent array entry.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_value = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_value = regs[k];
    end
  end

  // -------------------------------------------------------------------------
  // Write channel buffers and B response
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done <= 1'b0;
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      rst_done <= 1'b1;

      // A lone channel is parked until its partner arrives.
      if (aw_hs && !commit) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs && !commit) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end

      // Commit and B handshake are mutually exclusive: both READYs are low
      // while BVALID is high, so nothing can become available then.
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  // NOTE: the register array is reset (rather than left uninitialised like a
  // plain RAM) because it drives REG_OUT and software expects zeros.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && wr_in_range) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_idx == IDX_W'(k)) begin
            wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // an AR colliding with a write commit returns the old register contents.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= rd_in_range ? rd_value : '0;
            rresp   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp;
  assign S_AXI_RVALID = (r_state == R_RESP);
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = rresp;
  assign REG_WR_PULSE = wr_pulse;

  always_comb begin
    REG_OUT = '0;
    for (int k = 0; k < NUM_REGS; k++) REG_OUT[DATA_WIDTH*k +: DATA_WIDTH] = regs[k];
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axil_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_responder
//
// Two responders share one stimulus bus: dut (NUM_REGS=4) and dut3
// (NUM_REGS=3). Their handshake timing is identical, so the same
// transactions exercise in-range behaviour on dut and out-of-range behaviour
// on dut3 at address 0xC.
// ---------------------------------------------------------------------------
module tb_axil_reg_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         rready;

  // dut outputs
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  // dut3 outputs
  logic         awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]   bresp3, rresp3;
  logic [31:0]  rdata3;
  logic [95:0]  reg_out3;
  logic [2:0]   reg_wr_pulse3;

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .REG_WR_PULSE(reg_wr_pulse)
  );

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready3),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready3),
    .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready3),
    .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out3), .REG_WR_PULSE(reg_wr_pulse3)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled mid-cycle; a one-cycle pulse counts exactly once.
  int pulse_cnt [4] = '{0, 0, 0, 0};
  int pulse3_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(reg_wr_pulse[k]);
      pulse3_cnt += $countones(reg_wr_pulse3);
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Full write transaction, inputs driven at negedges; returns both B responses.
  task automatic run_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [1:0] resp3_o);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      n++;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_accepted", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    resp3_o = bresp3;
    @(negedge clk);
  endtask

  task automatic run_read(input logic [3:0] addr,
                          output logic [1:0] resp, output logic [31:0] data,
                          output logic [1:0] resp3_o, output logic [31:0] data3_o);
    bit ar_done;
    int n;
    ar_done = 1'b0; n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!ar_done && n < 50) begin
      ar_done = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    check("read_accepted", ar_done, 1'b1);
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check("rvalid_seen", rvalid, 1'b1);
    resp = rresp; data = rdata;
    resp3_o = rresp3; data3_o = rdata3;
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_read;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    bit          is_read;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic apply_vec(input vec_t v);
    exp_t        e;
    logic [1:0]  r, r3;
    logic [31:0] d, d3;
    exp_q.push_back('{v.is_read, v.exp_resp, v.exp_data});
    if (v.is_read) begin
      run_read(v.addr, r, d, r3, d3);
    end else begin
      run_write(v.addr, v.data, v.strb, r, r3);
      d = '0;
    end
    e = exp_q.pop_front();
    if (e.is_read) begin
      check("rresp", r, e.resp);
      check("rdata", d, e.data);
    end else begin
      check("bresp", r, e.resp);
    end
  endtask

  vec_t        vecs [10];
  vec_t        v;
  logic [1:0]  r, r3;
  logic [31:0] d, d3;
  int          p3_before;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_reg_out", reg_out, 128'h0);
    check("rst_rdata_resp", {rdata, rresp, bresp}, 36'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // ---------------- table: basic writes / reads / strobes ----------------
    vecs[0] = '{1'b0, 4'h0, 32'h0000_0001, 4'hF, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 4'h4, 32'h0000_0002, 4'hF, 2'b00, 32'h0};
    vecs[2] = '{1'b0, 4'h8, 32'h0000_0003, 4'hF, 2'b00, 32'h0};
    vecs[3] = '{1'b0, 4'hC, 32'h0000_0004, 4'hF, 2'b00, 32'h0};
    vecs[4] = '{1'b1, 4'h0, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
    vecs[5] = '{1'b1, 4'h4, 32'h0,         4'h0, 2'b00, 32'h0000_0002};
    vecs[6] = '{1'b1, 4'h8, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
    vecs[7] = '{1'b1, 4'hC, 32'h0,         4'h0, 2'b00, 32'h0000_0004};
    vecs[8] = '{1'b0, 4'h4, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    vecs[9] = '{1'b1, 4'h5, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD};

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      apply_vec(v);
      if (i == 7) begin
        check("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int k = 0; k < 4; k++) check("wr_pulse_count", pulse_cnt[k], 1);
      end
    end

    // ---------------- read/write collision on reg0 ----------------
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    check("collide_readies", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("collide_valids", {bvalid, rvalid}, 2'b11);
    check("collide_old_rdata", {rresp, rdata}, {2'b00, 32'h1});
    @(negedge clk);
    check("collide_drained", {bvalid, rvalid}, 2'b00);
    v = '{1'b1, 4'h0, 32'h0, 4'h0, 2'b00, 32'h77};
    apply_vec(v);

    // ---------------- W three cycles before AW, BREADY held low ----------------
    @(negedge clk);
    bready = 1'b0;
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("w_held_wready_low", wready, 1'b0);
    check("w_held_no_b", bvalid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    awaddr = 4'h8; awvalid = 1'b1;
    check("w_held_awready", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // A fresh AW/W is offered; it must not be taken while BVALID is high.
      awvalid = 1'b1; wvalid = 1'b1;
      check("b_hold", {bvalid, bresp, awready, wready}, {1'b1, 2'b00, 1'b0, 1'b0});
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    check("b_done_readies", {bvalid, awready, wready}, 3'b011);
    check("reg2_value", reg_out[95:64], 32'h55);

    // ---------------- out of range on the NUM_REGS=3 instance ----------------
    check("dut3_reg_out_before", reg_out3, 96'h00000055_00BB00DD_00000077);
    p3_before = pulse3_cnt;
    run_write(4'hC, 32'h9, 4'hF, r, r3);
    check("oor_bresp_in_range", r, 2'b00);
    check("oor_bresp3", r3, 2'b10);
    check("oor_reg_out3", reg_out3, 96'h00000055_00BB00DD_00000077);
    check("oor_no_pulse3", pulse3_cnt - p3_before, 0);
    check("oor_reg3_main", reg_out[127:96], 32'h9);
    run_read(4'hC, r, d, r3, d3);
    check("oor_read_main", {r, d}, {2'b00, 32'h9});
    check("oor_read3", {r3, d3}, {2'b10, 32'h0});

    // ---------------- reset with both responses pending ----------------
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 4'h0; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_reset_valids", {bvalid, rvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_valids", {bvalid, rvalid, bvalid3, rvalid3}, 4'b0000);
    check("reset_clears_regs", reg_out, 128'h0);
    check("reset_clears_regs3", reg_out3, 96'h0);
    check("reset_readies_low", {awready, wready, arready}, 3'b000);
    check("reset_clears_resp", {rdata, rresp, bresp}, 36'h0);
    @(negedge clk);
    bready = 1'b1; rready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale_resp", {bvalid, rvalid}, 2'b00);
    end
    check("post_reset2_readies", {awready, wready, arready}, 3'b111);
    v = '{1'b1, 4'h0, 32'h0, 4'h0, 2'b00, 32'h0};
    apply_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite slave (responder) register bank: the subordinate end that the lab VIP master drives with AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST.
- Holds NUM_REGS 32-bit software registers, flattened onto REG_OUT for the custom IP datapath.
- Write address and write data channels are buffered independently.
- Each write and each read is answered with exactly one response beat; out-of-range accesses return SLVERR.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width in bits.
- NUM_REGS, 4, number of implemented registers; must be between 1 and 2^(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- REG_OUT  out  NUM_REGS*32  register contents; reg k occupies bits [32k+31:32k].
- REG_WR_PULSE  out  NUM_REGS  one-cycle pulse on bit k when reg k is written.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers, REG_OUT, REG_WR_PULSE, BVALID, RVALID, BRESP, RRESP and RDATA go to 0.
  - Both holding buffers are cleared.
  - AWREADY, WREADY and ARREADY are 0 while reset is asserted, and go to 1 on the first edge after release.
  - A reset mid-transaction discards the in-flight AW, W or AR; no response is issued for it.
- Address index: idx = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] is ignored. Out of range means idx >= NUM_REGS.
- Write channel:
  - aw_held and w_held buffers each capture their channel on its handshake.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens on the edge where both are available (held, or handshaking that cycle):
    - In range: byte lane b of reg[idx] is updated iff WSTRB[b]=1; REG_WR_PULSE[idx]=1 for that one cycle.
    - Out of range: no register changes, no pulse.
    - Both buffers clear; BVALID=1 the next cycle.
  - BRESP is 00 for in-range, 10 for out-of-range; it stays stable while BVALID=1.
  - BVALID holds until the BVALID&&BREADY edge. READYs re-assert the cycle after the B handshake.
  - Latency: AW and W together in cycle N → BVALID in cycle N+1.
  - WSTRB=0 in range: no bytes change, pulse still fires, BRESP=OKAY.
- Read channel, two states (R_IDLE, R_RESP):
  - ARREADY=1 only in R_IDLE.
  - On the AR handshake: RDATA is latched from the register value before that edge's write commit (read-before-write on a same-cycle collision); RVALID=1 next cycle; state → R_RESP.
  - Out of range: RDATA=0, RRESP=10.
  - RDATA and RRESP stay stable while RVALID=1; R_RESP → R_IDLE on the RVALID&&RREADY edge.
  - Latency: AR in cycle N → RVALID in cycle N+1. Maximum throughput is one read per two cycles.
- Concurrency: the read and write paths are independent; one outstanding transaction per direction.
- REG_OUT is driven directly from the register flops, so it is valid the cycle after a commit.

Test Plan:
- Sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=F, then read back all four → every BRESP and RRESP = 00, RDATA = 1, 2, 3, 4; REG_OUT = 0x00000004_00000003_00000002_00000001; REG_WR_PULSE bits 0 through 3 pulse once each.
- Write 0xAABBCCDD to 0x4 with WSTRB=0101 over prior 0x00000002 → RDATA at 0x4 = 0x00BB00DD.
- Present W (0x55) three cycles before AW (0x8), with BREADY held low five cycles → WREADY stays low after the W handshake; BVALID holds with BRESP=00; no new AW/W accepted until the B handshake; reg2 = 0x55.
- NUM_REGS=3, write 0x9 and read at 0xC → BRESP=10, RRESP=10, RDATA=0, reg contents unchanged, no pulse.
- Read 0x0 in the same cycle the write of 0x77 to 0x0 commits (old value 0x1) → RDATA=0x1; a subsequent read returns 0x77.
- Assert ARESETN low while BVALID=1 and RVALID=1 → both drop immediately, all registers = 0, no stale response after release.
